// File: rtl/ysyx_22050550_mul_ctrl.sv
// Multiply sequencer that sits between EXU dispatch and the radix-4 Booth multiplier.
// It accepts one RV64M multiply op at a time, maps operands and sign mode onto the
// multiplier request, captures the 128-bit product, selects and sign-extends the
// architectural result, and holds it until writeback takes it. A small value-keyed
// cache of the last full product serves MUL directly when the operands match, which
// covers the common MULH* followed by MUL idiom without a second multiplier pass.
module ysyx_22050550_mul_ctrl #(
  parameter int unsigned REUSE_EN = 1,  // 1 = serve matching MUL from the cached low half
  parameter int unsigned RD_W     = 5   // destination register tag width
) (
  input  logic            clock,
  input  logic            reset,          // synchronous, active-low

  // Dispatch side
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [63:0]     in_src1,
  input  logic [63:0]     in_src2,
  input  logic [RD_W-1:0] in_rd,
  input  logic            flush,

  // Multiplier side
  output logic            mul_valid,
  output logic            mul_flush,
  output logic            mul_w,
  output logic [1:0]      mul_signed,
  output logic [63:0]     mul_a,
  output logic [63:0]     mul_b,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  input  logic [63:0]     mul_res_h,
  input  logic [63:0]     mul_res_l,

  // Writeback side
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_data,
  output logic [RD_W-1:0] out_rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Normalised op kinds; the three unused raw encodings collapse onto OP_MUL.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_MULW   = 3'b100
  } op_e;

  function automatic op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'b001:  decode_op = OP_MULH;
      3'b010:  decode_op = OP_MULHSU;
      3'b011:  decode_op = OP_MULHU;
      3'b100:  decode_op = OP_MULW;
      default: decode_op = OP_MUL;
    endcase
  endfunction

  // Architectural result from the raw 128-bit product.
  function automatic logic [63:0] select_result(input op_e       op,
                                                input logic [63:0] hi,
                                                input logic [63:0] lo);
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: select_result = hi;
      OP_MULW:                      select_result = {{32{lo[31]}}, lo[31:0]};
      default:                      select_result = lo;
    endcase
  endfunction

  // Control state and registered outputs
  state_e          state_q;
  logic            out_valid_q;
  logic [63:0]     out_data_q;
  logic [RD_W-1:0] out_rd_q;
  logic            c_valid_q;

  // Latched operation (datapath, no reset needed)
  op_e             op_q;
  logic [63:0]     src1_q;
  logic [63:0]     src2_q;

  // Last full product, keyed by operand values
  logic [63:0]     c_src1_q;
  logic [63:0]     c_src2_q;
  logic [63:0]     c_lo_q;

  // Combinational helpers
  op_e             op_d;
  logic            accept;
  logic            reuse_hit;
  logic            capture;
  logic            cache_wr;
  logic [63:0]     result_d;

  assign op_d   = decode_op(in_op);

  // flush wins over a new request in IDLE: nothing is taken that cycle.
  assign accept = (state_q == S_IDLE) && in_valid && !flush;

  // Low 64 bits of a product do not depend on signedness, so any cached non-W
  // product answers a MUL with the same operand values.
  assign reuse_hit = (REUSE_EN != 0) && (op_d == OP_MUL) && c_valid_q
                  && (in_src1 == c_src1_q) && (in_src2 == c_src2_q);

  // A product arriving together with flush belongs to a killed op and is dropped.
  assign capture  = (state_q == S_WAIT) && mul_out_valid && !flush;
  assign cache_wr = capture && (op_q != OP_MULW);
  assign result_d = select_result(op_q, mul_res_h, mul_res_l);

  // Sequencer: state, result registers and the cache valid bit.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register in
    // this block samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      out_rd_q    <= '0;
      c_valid_q   <= 1'b0;
    end else if (flush) begin
      // Kill whatever is in flight; the cache is value-keyed and stays valid.
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            out_rd_q <= in_rd;
            if (reuse_hit) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= c_lo_q;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // mul_valid mirrors mul_ready here, so leaving on mul_ready gives a
          // single-cycle request that the multiplier is guaranteed to take.
          if (mul_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_out_valid) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= result_d;
            if (op_q != OP_MULW) c_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Operand latch and cache payload.
  always_ff @(posedge clock) begin
    // NOTE: these are pure datapath registers qualified by the control state or by
    // c_valid_q, so they carry no reset; garbage in them is never observed.
    if (accept) begin
      op_q   <= op_d;
      src1_q <= in_src1;
      src2_q <= in_src2;
    end
    if (cache_wr) begin
      c_src1_q <= src1_q;
      c_src2_q <= src2_q;
      c_lo_q   <= mul_res_l;
    end
  end

  // Sign mode for the multiplier: {src1 signed, src2 signed}.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    mul_signed = 2'b11;
    if (op_q == OP_MULHSU)     mul_signed = 2'b10;
    else if (op_q == OP_MULHU) mul_signed = 2'b00;
  end

  // Multiplier request, driven from latched registers so it is stable ISSUE..WAIT.
  assign mul_w     = (op_q == OP_MULW);
  assign mul_a     = mul_w ? {{32{src1_q[31]}}, src1_q[31:0]} : src1_q;
  assign mul_b     = mul_w ? {{32{src2_q[31]}}, src2_q[31:0]} : src2_q;
  assign mul_valid = (state_q == S_ISSUE) && mul_ready;
  assign mul_flush = flush && (state_q == S_WAIT);

  // Dispatch and writeback handshakes.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_ysyx_22050550_mul_ctrl.sv
// Self-checking bench for ysyx_22050550_mul_ctrl. A behavioural multiplier
// (32-cycle busy, 16 for W ops) answers the controller; expected results come from
// plain signed/unsigned arithmetic on the dispatched operands, and expected
// latency from a small operand cache model.
module tb_ysyx_22050550_mul_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [63:0] in_src1 = 64'd0;
  logic [63:0] in_src2 = 64'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        flush = 1'b0;
  logic        mul_valid;
  logic        mul_flush;
  logic        mul_w;
  logic [1:0]  mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic        mul_ready = 1'b1;
  logic        mul_out_valid = 1'b0;
  logic [63:0] mul_res_h = 64'd0;
  logic [63:0] mul_res_l = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_rd;

  ysyx_22050550_mul_ctrl #(.REUSE_EN(1), .RD_W(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .flush(flush),
    .mul_valid(mul_valid), .mul_flush(mul_flush), .mul_w(mul_w),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_out_valid(mul_out_valid),
    .mul_res_h(mul_res_h), .mul_res_l(mul_res_l),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural multiplier ----------------
  function automatic logic [127:0] ext128(input logic [63:0] v, input logic s);
    ext128 = s ? {{64{v[63]}}, v} : {64'd0, v};
  endfunction

  logic         m_rst_n, m_take, m_flush;
  logic [127:0] m_prod_next, m_prod;
  int           m_lat_next;
  int           m_cnt = 0;
  bit           m_busy = 1'b0;
  bit           m_drain = 1'b0;
  int           mv_pulses = 0;

  always @(posedge clock) begin
    m_rst_n     = reset;
    m_take      = mul_valid && mul_ready;
    m_flush     = mul_flush;
    if (mul_valid) mv_pulses++;
    m_prod_next = ext128(mul_a, mul_signed[1]) * ext128(mul_b, mul_signed[0]);
    m_lat_next  = mul_w ? 16 : 32;
    #2;
    mul_out_valid = 1'b0;
    if (!m_rst_n) begin
      m_busy = 1'b0; m_drain = 1'b0; m_cnt = 0; mul_ready = 1'b1;
    end else if (m_flush) begin
      m_busy = 1'b0; m_cnt = 0; mul_ready = 1'b0; m_drain = 1'b1;
    end else if (m_drain) begin
      m_drain = 1'b0; mul_ready = 1'b1;
    end else if (m_take) begin
      m_busy = 1'b1; m_cnt = m_lat_next; mul_ready = 1'b0; m_prod = m_prod_next;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0; mul_ready = 1'b1; mul_out_valid = 1'b1;
        mul_res_h = m_prod[127:64];
        mul_res_l = m_prod[63:0];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [2:0] op,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    logic signed [31:0]  wa, wb, w32;
    logic signed [63:0]  r;
    sa = $signed(a);  sb = $signed(b);
    ua = {64'd0, a};  ub = {64'd0, b};
    case (op)
      3'b001: begin p = sa * sb; r = p[127:64]; end
      3'b010: begin p = sa * ub; r = p[127:64]; end
      3'b011: begin p = ua * ub; r = p[127:64]; end
      3'b100: begin wa = a[31:0]; wb = b[31:0]; w32 = wa * wb; r = w32; end
      default: begin p = sa * sb; r = p[63:0]; end
    endcase
    ref_result = r;
  endfunction

  function automatic logic [63:0] sext32(input logic [63:0] v);
    logic signed [31:0] t;
    logic signed [63:0] r;
    t = v[31:0];
    r = t;
    sext32 = r;
  endfunction

  // Cache model: last operands of a completed non-W op.
  bit          cm_valid = 1'b0;
  logic [63:0] cm_s1, cm_s2;

  // Full op: dispatch, check the request, wait for result, optionally stall
  // writeback for 'hold' cycles, then hand it off.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input int hold);
    logic [63:0] exp;
    logic [1:0]  exp_sgn;
    bit          hit;
    int          exp_lat, lat, p0;
    hit     = (op == 3'b000 || op > 3'b100) && cm_valid && a == cm_s1 && b == cm_s2;
    exp     = ref_result(op, a, b);
    exp_lat = hit ? 1 : ((op == 3'b100) ? 19 : 35);
    exp_sgn = (op == 3'b010) ? 2'b10 : ((op == 3'b011) ? 2'b00 : 2'b11);
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
    p0 = mv_pulses;
    step();
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_src1  = {$urandom, $urandom};
    in_src2  = {$urandom, $urandom};
    in_rd    = 5'($urandom);
    check({tag, ".mul_valid_c1"}, 64'(mul_valid), 64'(!hit));
    if (!hit) begin
      check({tag, ".mul_signed"}, 64'(mul_signed), 64'(exp_sgn));
      check({tag, ".mul_w"}, 64'(mul_w), 64'(op == 3'b100));
      check({tag, ".mul_a"}, mul_a, (op == 3'b100) ? sext32(a) : a);
      check({tag, ".mul_b"}, mul_b, (op == 3'b100) ? sext32(b) : b);
    end
    lat = 1;
    while (!out_valid && lat < 60) begin
      step();
      lat++;
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".out_data"}, out_data, exp);
    check({tag, ".out_rd"}, 64'(out_rd), 64'(rd));
    check({tag, ".mul_pulses"}, 64'(mv_pulses - p0), hit ? 64'd0 : 64'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      step();
      check({tag, ".hold_data"}, out_data, exp);
      check({tag, ".hold_rd"}, 64'(out_rd), 64'(rd));
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
    if (op != 3'b100 && !hit) begin
      cm_valid = 1'b1; cm_s1 = a; cm_s2 = b;
    end
  endtask

  // Dispatch without waiting for the result.
  task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_rd = 5'd9;
    step();
    in_valid = 1'b0;
  endtask

  logic [63:0] ra, rb, pa, pb;
  logic [2:0]  rop;
  int          seen;

  initial begin
    // Reset values
    repeat (3) step();
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.mul_valid", 64'(mul_valid), 64'd0);
    check("rst.mul_flush", 64'(mul_flush), 64'd0);
    check("rst.out_data", out_data, 64'd0);
    check("rst.out_rd", 64'(out_rd), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    step();

    // 1: MULHU of all ones
    do_op("t1_mulhu", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 0);
    check("t1.value", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
    // 2: MULW overflow into the sign bit
    do_op("t2_mulw", 3'b100, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd3, 0);
    check("t2.value", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
    // 3: MULH then MUL with the same operands hits the cache
    do_op("t3_mulh", 3'b001, -64'sd3, 64'd5, 5'd4, 0);
    do_op("t3_mul_hit", 3'b000, -64'sd3, 64'd5, 5'd5, 0);
    check("t3.value", out_data, 64'hFFFF_FFFF_FFFF_FFF1);
    // 4: MULHSU
    do_op("t4_mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 0);

    // 5: flush in WAIT, then a fresh MUL
    start_op(3'b000, 64'd123, 64'd456);
    repeat (9) step();
    flush = 1'b1;
    #1;
    check("t5.mul_flush", 64'(mul_flush), 64'd1);
    step();
    flush = 1'b0;
    check("t5.in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      step();
    end
    check("t5.no_out_valid", 64'(seen), 64'd0);
    do_op("t5_mul", 3'b000, 64'd6, 64'd7, 5'd8, 0);
    check("t5.value", out_data, 64'd42);

    // flush beats in_valid in IDLE
    in_valid = 1'b1; in_op = 3'b000; in_src1 = 64'd1; in_src2 = 64'd1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("prio.in_ready", 64'(in_ready), 64'd1);
    check("prio.mul_valid", 64'(mul_valid), 64'd0);

    // 6: writeback stall, then reset in WAIT clears state and cache
    do_op("t6_stall", 3'b000, 64'h1234, 64'h5678, 5'd21, 5);
    start_op(3'b001, 64'd77, 64'd88);
    repeat (9) step();
    reset = 1'b0;
    step();
    check("t6.rst_out_valid", 64'(out_valid), 64'd0);
    check("t6.rst_mul_valid", 64'(mul_valid), 64'd0);
    check("t6.rst_mul_flush", 64'(mul_flush), 64'd0);
    check("t6.rst_out_data", out_data, 64'd0);
    check("t6.rst_out_rd", 64'(out_rd), 64'd0);
    check("t6.rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    cm_valid = 1'b0;
    step();
    do_op("t6_nohit", 3'b000, 64'h1234, 64'h5678, 5'd22, 0);

    // Randomised ops, with frequent operand reuse to exercise the cache
    pa = 64'd0; pb = 64'd0;
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(7, 0));
      case ($urandom_range(3, 0))
        0: begin
          ra = pa; rb = pb;
          if ($urandom_range(1, 0) == 1) rop = 3'b000;
        end
        1: begin
          ra = 64'($signed(32'($urandom_range(200, 0)) - 32'd100));
          rb = 64'($signed(32'($urandom_range(200, 0)) - 32'd100));
        end
        default: begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
        end
      endcase
      do_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom), $urandom_range(3, 0));
      pa = ra; pb = rb;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
